weight_buf_ctrl: RTL and testbench
==================================

// Module: weight_buf_ctrl
// PURPOSE
//  Ping-pong controller for the weight DRM bank pair. Counts width-converted DDR beats into one
//  bank while the MAC array streams the other bank. Generates write/read addresses and bank
//  selects, re-reads each tile cfg_reuse times, and pulses layer_done after the last tile.
//  Sits between the DDR width converter, the WeightDRM and the top-level layer FSM.
// PARAMETERS
//  WR_ADDR_DEPTH  10  write address width (DRM write-port words per bank)
//  RD_ADDR_DEPTH  8   read address width (DRM read-port words per bank)
//  RD_LATENCY     2   DRM read latency in cycles; rd_valid = rd_en delayed by this (>=1)
//  TILE_CNT_W     8   width of the tile counter
//  REUSE_W        4   width of the reuse counter
// PORTS
//  clk           in   1              single clock; all logic rising-edge
//  rst           in   1              synchronous, active-high reset
//  cfg_load      in   1              pulse: latch cfg_*; accepted only when busy==0
//  cfg_wr_len    in   WR_ADDR_DEPTH  write beats per tile minus 1
//  cfg_rd_len    in   RD_ADDR_DEPTH  read words per tile minus 1
//  cfg_reuse     in   REUSE_W        passes per tile minus 1
//  cfg_tiles     in   TILE_CNT_W     tiles per layer minus 1
//  wr_valid      in   1              converter beat valid
//  wr_ready      out  1              beat accepted when wr_valid&wr_ready
//  wr_en         out  1              DRM write strobe (= wr_valid&wr_ready, combinational)
//  wr_bank       out  1              bank being filled
//  wr_addr       out  WR_ADDR_DEPTH  DRM write address
//  rd_start      in   1              MAC requests next tile
//  rd_en         out  1              DRM read strobe
//  rd_bank       out  1              bank being read
//  rd_addr       out  RD_ADDR_DEPTH  DRM read address
//  rd_valid      out  1              read data valid at DRM output
//  rd_last       out  1              aligned with rd_valid on final word of final pass of a tile
//  busy          out  1              layer in progress
//  layer_done    out  1              one-cycle pulse after last tile fully read
// BEHAVIOUR
//  Reset: all outputs 0; bank_full[1:0]=0; wr_bank=rd_bank=0; FSMs idle; RD_LATENCY pipe cleared.
//  Reset mid-operation aborts everything the next cycle; in-flight rd_valid is dropped.
//  cfg_load while busy==0: latch cfg, busy<=1, tile counters <=0. While busy==1: ignored.
//  Write FSM W_IDLE->W_FILL when busy and bank_full[wr_bank]==0 and tiles remain to load.
//   W_FILL: wr_ready=1; each accepted beat wr_addr++. On the beat where wr_addr==cfg_wr_len:
//   bank_full[wr_bank]<=1, wr_bank toggles, wr_addr<=0, loaded-tile count++, go to W_WAIT.
//   W_WAIT: wr_ready=0 until bank_full[wr_bank]==0 -> W_FILL, or all tiles loaded -> W_IDLE.
//   wr_ready=0 in W_IDLE and W_WAIT. A full bank is never overwritten.
//  Read FSM R_IDLE->R_RUN on rd_start when bank_full[rd_bank]==1.
//   rd_start with the bank not full is held pending; accept on first cycle bank becomes full.
//   R_RUN: rd_en=1 every cycle; rd_addr 0..cfg_rd_len, wraps to 0 for each of cfg_reuse+1 passes.
//   After final word issued: bank_full[rd_bank]<=0, rd_bank toggles, read-tile count++, -> R_DRAIN.
//   R_DRAIN: wait RD_LATENCY cycles for pipe empty; -> R_IDLE.
//   Last tile: layer_done pulses the cycle R_DRAIN exits; busy<=0 that cycle.
//  rd_last travels the same RD_LATENCY pipe as rd_valid.
//  Same-cycle write-complete on one bank and read-free on the other: both updates apply.
//  Same-cycle free and W_WAIT check of the same bank: W_WAIT sees it free next cycle.
//  Counters are compared with ==; no overflow possible given minus-1 encoding.
//  cfg_tiles==0: single tile; cfg_reuse==0: single pass.
// CONFIGURATION
//  WBC_PERF_CNT_EN defined: adds outputs perf_wr_stall[31:0] and perf_rd_stall[31:0].
//   perf_wr_stall counts cycles in W_WAIT with wr_valid=1.
//   perf_rd_stall counts cycles a rd_start is pending with the bank not full.
//   Both saturate at 2^32-1 and clear on rst or accepted cfg_load.
//  Not defined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  T1: rst mid-R_RUN -> next cycle rd_en=0, rd_valid=0 after reset, busy=0, bank_full=0.
//  T2: cfg wr_len=3, rd_len=1, reuse=1, tiles=0; 4 beats, then rd_start ->
//      wr_addr 0..3 on bank0; rd_addr 0,1,0,1 on bank0; rd_last on 4th rd_valid;
//      layer_done 1 cycle after drain.
//  T3: tiles=3, wr_valid constant, rd_start held high -> bank order 0,1,0,1 both sides;
//      wr_ready=0 whenever both banks full; exactly 4 rd_last, 1 layer_done.
//  T4: rd_start before any write -> no rd_en until bank0 full; rd_en on first cycle after.
//  T5: cfg_load with new values while busy -> ignored; later load after layer_done accepted.
//  T6 (WBC_PERF_CNT_EN): read stalled 10 cycles with wr_valid=1 in W_WAIT ->
//      perf_wr_stall=10; cfg_load clears it to 0.

Source files
------------

// File: rtl/weight_buf_ctrl.sv
// weight_buf_ctrl: ping-pong fill/stream controller for the weight DRM bank pair.
// Define WBC_PERF_CNT_EN to add the perf_wr_stall / perf_rd_stall counters.
module weight_buf_ctrl #(
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int RD_LATENCY    = 2,
  parameter int TILE_CNT_W    = 8,
  parameter int REUSE_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [WR_ADDR_DEPTH-1:0] cfg_wr_len,
  input  logic [RD_ADDR_DEPTH-1:0] cfg_rd_len,
  input  logic [REUSE_W-1:0]       cfg_reuse,
  input  logic [TILE_CNT_W-1:0]    cfg_tiles,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     wr_en,
  output logic                     wr_bank,
  output logic [WR_ADDR_DEPTH-1:0] wr_addr,
  input  logic                     rd_start,
  output logic                     rd_en,
  output logic                     rd_bank,
  output logic [RD_ADDR_DEPTH-1:0] rd_addr,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     layer_done
`ifdef WBC_PERF_CNT_EN
  ,
  output logic [31:0]              perf_wr_stall,
  output logic [31:0]              perf_rd_stall
`endif
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FILL  = 2'd1;
  localparam logic [1:0] W_WAIT  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_DRAIN = 2'd2;

  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  logic [1:0]               w_state;
  logic [1:0]               r_state;
  logic [WR_ADDR_DEPTH-1:0] wr_len_q;
  logic [RD_ADDR_DEPTH-1:0] rd_len_q;
  logic [REUSE_W-1:0]       reuse_q;
  logic [REUSE_W-1:0]       pass_q;
  logic [TILE_CNT_W-1:0]    tiles_q;
  logic [TILE_CNT_W-1:0]    wr_tile_q;
  logic [TILE_CNT_W-1:0]    rd_tile_q;
  logic                     wr_all_q;
  logic                     rd_fin_q;
  logic                     rd_pend;
  logic [1:0]               bank_full;
  logic [1:0]               bank_full_d;
  logic [DW-1:0]            drain_q;
  logic [RD_LATENCY-1:0]    vpipe;
  logic [RD_LATENCY-1:0]    lpipe;

  logic cfg_ok;
  logic wr_tile_end;
  logic rd_word_end;
  logic rd_tile_end;
  logic rd_req;
  logic rd_go;
  logic drain_end;

  assign cfg_ok      = cfg_load && !busy;
  assign wr_ready    = (w_state == W_FILL);
  assign wr_en       = wr_valid && wr_ready;
  assign wr_tile_end = wr_en && (wr_addr == wr_len_q);
  assign rd_en       = (r_state == R_RUN);
  assign rd_word_end = rd_en && (rd_addr == rd_len_q);
  assign rd_tile_end = rd_word_end && (pass_q == reuse_q);
  assign rd_req      = rd_start || rd_pend;
  assign rd_go       = (r_state == R_IDLE) && busy && rd_req
                     && bank_full[rd_bank] && !rd_fin_q;
  assign drain_end   = (r_state == R_DRAIN)
                     && (drain_q == DW'(RD_LATENCY - 1));
  assign rd_valid    = vpipe[RD_LATENCY-1];
  assign rd_last     = lpipe[RD_LATENCY-1];

  // Fill and free always hit opposite banks, so both may land together.
  always_comb begin
    bank_full_d = bank_full;
    if (wr_tile_end) bank_full_d[wr_bank] = 1'b1;
    if (rd_tile_end) bank_full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      bank_full <= 2'b00;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      reuse_q   <= '0;
      tiles_q   <= '0;
    end else begin
      bank_full <= bank_full_d;
      if (cfg_ok) begin
        busy     <= 1'b1;
        wr_len_q <= cfg_wr_len;
        rd_len_q <= cfg_rd_len;
        reuse_q  <= cfg_reuse;
        tiles_q  <= cfg_tiles;
      end else if (drain_end && rd_fin_q) begin
        busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      wr_tile_q <= '0;
      wr_all_q  <= 1'b0;
    end else begin
      if (cfg_ok) begin
        wr_tile_q <= '0;
        wr_all_q  <= 1'b0;
      end
      unique case (w_state)
        W_IDLE: begin
          if (busy && !wr_all_q && !bank_full[wr_bank])
            w_state <= W_FILL;
        end
        W_FILL: begin
          if (wr_tile_end) begin
            wr_addr   <= '0;
            wr_bank   <= ~wr_bank;
            wr_tile_q <= wr_tile_q + 1'b1;
            wr_all_q  <= (wr_tile_q == tiles_q);
            w_state   <= W_WAIT;
          end else if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        W_WAIT: begin
          if (wr_all_q)
            w_state <= W_IDLE;
          else if (!bank_full[wr_bank])
            w_state <= W_FILL;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      pass_q     <= '0;
      rd_tile_q  <= '0;
      rd_fin_q   <= 1'b0;
      rd_pend    <= 1'b0;
      drain_q    <= '0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      if (cfg_ok) begin
        rd_tile_q <= '0;
        rd_fin_q  <= 1'b0;
        rd_pend   <= 1'b0;
      end
      unique case (r_state)
        R_IDLE: begin
          if (rd_go) begin
            r_state <= R_RUN;
            rd_pend <= 1'b0;
            rd_addr <= '0;
            pass_q  <= '0;
          end else if (busy && rd_start && !rd_fin_q) begin
            rd_pend <= 1'b1;
          end
        end
        R_RUN: begin
          if (rd_tile_end) begin
            rd_addr   <= '0;
            pass_q    <= '0;
            rd_bank   <= ~rd_bank;
            rd_tile_q <= rd_tile_q + 1'b1;
            rd_fin_q  <= (rd_tile_q == tiles_q);
            drain_q   <= '0;
            r_state   <= R_DRAIN;
          end else if (rd_word_end) begin
            rd_addr <= '0;
            pass_q  <= pass_q + 1'b1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        R_DRAIN: begin
          if (drain_end) begin
            r_state    <= R_IDLE;
            layer_done <= rd_fin_q;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Read-valid/last delay line matching the DRM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= rd_en;
      lpipe[0] <= rd_tile_end;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

`ifdef WBC_PERF_CNT_EN
  logic rd_stall;
  assign rd_stall = (r_state == R_IDLE) && busy && rd_req
                  && !bank_full[rd_bank] && !rd_fin_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_ok) begin
      perf_wr_stall <= '0;
      perf_rd_stall <= '0;
    end else begin
      if ((w_state == W_WAIT) && wr_valid && (perf_wr_stall != '1))
        perf_wr_stall <= perf_wr_stall + 1'b1;
      if (rd_stall && (perf_rd_stall != '1))
        perf_rd_stall <= perf_rd_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_buf_ctrl.sv
// tb_weight_buf_ctrl: directed tests for weight_buf_ctrl with a
// tile/word-count reference model checked every cycle.
module tb_weight_buf_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [9:0]  cfg_wr_len = '0;
  logic [7:0]  cfg_rd_len = '0;
  logic [3:0]  cfg_reuse = '0;
  logic [7:0]  cfg_tiles = '0;
  logic        wr_valid = 1'b0;
  logic        rd_start = 1'b0;
  logic        wr_ready, wr_en, wr_bank;
  logic [9:0]  wr_addr;
  logic        rd_en, rd_bank, rd_valid, rd_last;
  logic [7:0]  rd_addr;
  logic        busy, layer_done;
`ifdef WBC_PERF_CNT_EN
  logic [31:0] perf_wr_stall, perf_rd_stall;
`endif

  weight_buf_ctrl #(
    .WR_ADDR_DEPTH(10), .RD_ADDR_DEPTH(8), .RD_LATENCY(L),
    .TILE_CNT_W(8), .REUSE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len),
    .cfg_reuse(cfg_reuse), .cfg_tiles(cfg_tiles),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_start(rd_start),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .layer_done(layer_done)
`ifdef WBC_PERF_CNT_EN
    , .perf_wr_stall(perf_wr_stall), .perf_rd_stall(perf_rd_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model state: tile/word counts, not controller states.
  int  c_wrl, c_rdl, c_reuse, c_tiles;
  int  m_wbeat, m_wg, m_wl, m_rw, m_rg, m_rl;
  bit  m_busy, m_ld, armed;
  bit  hv[L], hl[L], hf[L];
  int  wlog_a[$], wlog_b[$], rlog_a[$], rlog_b[$], vlast[$];
  int  ld_cnt = 0, rl_cnt = 0;
  int  last_wr_cyc, first_rd_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit ld_n, acc, lw, fin;
    if (armed) begin
      chk("busy", busy, m_busy);
      chk("layer_done", layer_done, m_ld);
      chk("rd_valid", rd_valid, hv[L-1]);
      chk("rd_last", rd_last, hl[L-1]);
      chk("wr_en", wr_en, wr_valid && wr_ready);
      if (m_wg - m_rg >= 2) chk("wr_ready_full", wr_ready, 0);
      if (wr_en) begin
        chk("wr_addr", wr_addr, m_wbeat);
        chk("wr_bank", wr_bank, m_wg % 2);
        chk("wr_overrun", m_busy && (m_wg - m_rg < 2)
            && (m_wl <= c_tiles), 1);
        wlog_a.push_back(int'(wr_addr));
        wlog_b.push_back(int'(wr_bank));
        last_wr_cyc = cyc;
      end
      if (rd_en) begin
        chk("rd_addr", rd_addr, m_rw % (c_rdl + 1));
        chk("rd_bank", rd_bank, m_rg % 2);
        chk("rd_underrun", m_busy && (m_rg < m_wg), 1);
        if (rlog_a.size() == 0) first_rd_cyc = cyc;
        rlog_a.push_back(int'(rd_addr));
        rlog_b.push_back(int'(rd_bank));
      end
      if (rd_valid) vlast.push_back(int'(rd_last));
      if (rd_valid && rd_last) rl_cnt++;
      if (layer_done) ld_cnt++;
    end
    // advance model to the next cycle
    ld_n = hv[L-1] && hf[L-1];
    acc = cfg_load && !m_busy;
    for (int i = L - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      hl[i] = hl[i-1];
      hf[i] = hf[i-1];
    end
    lw = 0;
    fin = 0;
    if (rd_en) begin
      m_rw++;
      if (m_rw == (c_rdl + 1) * (c_reuse + 1)) begin
        m_rw = 0;
        lw = 1;
        fin = (m_rl == c_tiles);
        m_rg++;
        m_rl++;
      end
    end
    hv[0] = rd_en;
    hl[0] = lw;
    hf[0] = fin;
    if (wr_en) begin
      m_wbeat++;
      if (m_wbeat == c_wrl + 1) begin
        m_wbeat = 0;
        m_wg++;
        m_wl++;
      end
    end
    m_ld = ld_n;
    if (ld_n) m_busy = 0;
    if (acc) begin
      m_busy = 1;
      c_wrl = int'(cfg_wr_len);
      c_rdl = int'(cfg_rd_len);
      c_reuse = int'(cfg_reuse);
      c_tiles = int'(cfg_tiles);
      m_wl = 0;
      m_rl = 0;
    end
    if (rst) begin
      m_wbeat = 0; m_wg = 0; m_wl = 0;
      m_rw = 0; m_rg = 0; m_rl = 0;
      m_busy = 0; m_ld = 0;
      for (int i = 0; i < L; i++) begin
        hv[i] = 0; hl[i] = 0; hf[i] = 0;
      end
      armed = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
    step(1);
  endtask

  task automatic load(input int wl, input int rl, input int ru,
                      input int tl);
    cfg_wr_len = 10'(wl);
    cfg_rd_len = 8'(rl);
    cfg_reuse = 4'(ru);
    cfg_tiles = 8'(tl);
    cfg_load = 1;
    step(1);
    cfg_load = 0;
  endtask

  task automatic clear_logs();
    wlog_a.delete(); wlog_b.delete();
    rlog_a.delete(); rlog_b.delete();
    vlast.delete();
  endtask

  task automatic beats(input int n, input int budget);
    int got = 0;
    int t = 0;
    wr_valid = 1;
    while (got < n && t < budget) begin
      @(negedge clk);
      if (wr_en) got++;
      t++;
    end
    @(posedge clk);
    #1;
    wr_valid = 0;
    if (got < n) chk("beats_timeout", got, n);
  endtask

  task automatic rd_pulse();
    rd_start = 1;
    step(1);
    rd_start = 0;
  endtask

  task automatic wait_ld(input int budget);
    int t = 0;
    bit seen = 0;
    while (!seen && t < budget) begin
      @(negedge clk);
      seen = layer_done;
      t++;
    end
    if (!seen) chk("layer_done_timeout", 0, 1);
    step(1);
  endtask

  function automatic int qa(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int ld0, rl0, t;
    int e2[4];
    step(3);
    rst = 0;
    step(1);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_layer_done", layer_done, 0);

    // T2: single tile, two passes of two words
    step(1);
    load(3, 1, 1, 0);
    clear_logs();
    beats(4, 40);
    rd_pulse();
    wait_ld(60);
    e2 = '{0, 1, 0, 1};
    chk("t2_wr_n", wlog_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr_addr", qa(wlog_a, i), i);
      chk("t2_wr_bank", qa(wlog_b, i), 0);
      chk("t2_rd_addr", qa(rlog_a, i), e2[i]);
      chk("t2_rd_bank", qa(rlog_b, i), 0);
      chk("t2_rd_last", qa(vlast, i), (i == 3) ? 1 : 0);
    end
    chk("t2_rd_n", rlog_a.size(), 4);

    // T3: four tiles streamed with both sides held active
    do_reset();
    load(3, 2, 0, 3);
    clear_logs();
    ld0 = ld_cnt;
    rl0 = rl_cnt;
    wr_valid = 1;
    rd_start = 1;
    wait_ld(400);
    wr_valid = 0;
    rd_start = 0;
    step(6);
    chk("t3_wr_n", wlog_a.size(), 16);
    chk("t3_rd_n", rlog_a.size(), 12);
    for (int i = 0; i < 4; i++) begin
      chk("t3_wr_bank", qa(wlog_b, i * 4), i % 2);
      chk("t3_rd_bank", qa(rlog_b, i * 3), i % 2);
    end
    chk("t3_rd_last_n", rl_cnt - rl0, 4);
    chk("t3_layer_done_n", ld_cnt - ld0, 1);

    // T4: read request ahead of any data
    do_reset();
    load(1, 0, 0, 0);
    clear_logs();
    rd_pulse();
    step(5);
    chk("t4_no_early_rd", rlog_a.size(), 0);
    beats(2, 20);
    wait_ld(40);
    chk("t4_rd_n", rlog_a.size(), 1);
    chk("t4_rd_delay", first_rd_cyc - last_wr_cyc, 2);

    // T5: reload while busy is ignored, reload after done accepted
    do_reset();
    load(1, 0, 0, 0);
    load(5, 3, 2, 1);
    clear_logs();
    wr_valid = 1;
    step(10);
    wr_valid = 0;
    chk("t5_ignored_len", wlog_a.size(), 2);
    rd_pulse();
    wait_ld(40);
    load(2, 1, 0, 0);
    clear_logs();
    @(negedge clk);
    chk("t5_reload_busy", busy, 1);
`ifdef WBC_PERF_CNT_EN
    chk("t5_perf_wr_clr", perf_wr_stall, 0);
    chk("t5_perf_rd_clr", perf_rd_stall, 0);
`endif
    step(1);
    beats(3, 20);
    rd_pulse();
    wait_ld(40);
    for (int i = 0; i < 3; i++)
      chk("t5_wr_addr", qa(wlog_a, i), i);
    chk("t5_rd_n", rlog_a.size(), 2);

    // T1: reset in the middle of a read pass
    do_reset();
    load(3, 1, 3, 0);
    beats(4, 20);
    rd_pulse();
    t = 0;
    while (!rd_en && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t1_rd_started", rd_en, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_rd_en", rd_en, 0);
    chk("t1_rd_valid", rd_valid, 0);
    chk("t1_busy", busy, 0);
    step(1);
    rst = 0;
    step(1);
    load(0, 0, 0, 0);
    clear_logs();
    beats(1, 10);
    chk("t1_wr_bank0", qa(wlog_b, 0), 0);
    rd_pulse();
    wait_ld(30);
    chk("t1_rd_bank0", qa(rlog_b, 0), 0);

    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
